// File: rtl/ippcrc_crc12_chk56.sv
// ippcrc_crc12_chk56 -- CRC-12 checker for framed 56-bit payload words.
//
// Generator x^12+x^11+x^3+x^2+x+1 (12'h80F), non-reflected. Within each
// word di[0] is the first bit on the line and di[55] is the last.
//
// Parameters:
//   CRC_INIT   : CRC register seed loaded on every start-of-frame word
//   CRC_XOROUT : value XORed into the final CRC before it is compared
//
// Ports:
//   clk        : clock; all state changes on its rising edge
//   rst        : asynchronous, active-high reset
//   di_vld     : data word valid this cycle
//   di_sop     : first word of frame (qualified by di_vld)
//   di_eop     : last word of frame (qualified by di_vld)
//   di[55:0]   : payload word
//   fcs[11:0]  : received CRC, sampled only on the di_eop word
//   chk_vld    : one-cycle pulse, a frame result is available
//   chk_err    : CRC mismatch for the reported frame (valid with chk_vld)
//   crc_o      : final CRC (after XOROUT) of the last reported frame
//   proto_err  : one-cycle pulse on a framing violation
//   good_cnt   : count of good frames (saturating)
//   bad_cnt    : count of bad frames (saturating)
//
// Optional feature: define IPPCRC_CHK_CNT_EN to build the good/bad frame
// counters. Without it both counter outputs are tied to zero.

module ippcrc_crc12_chk56 #(
  parameter logic [11:0] CRC_INIT   = 12'h000,
  parameter logic [11:0] CRC_XOROUT = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        di_vld,
  input  logic        di_sop,
  input  logic        di_eop,
  input  logic [55:0] di,
  input  logic [11:0] fcs,
  output logic        chk_vld,
  output logic        chk_err,
  output logic [11:0] crc_o,
  output logic        proto_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [11:0] crc_q, crc_nxt;
  logic [11:0] crc_base, crc_step, crc_fin;
  logic        rpt, perr;

  // Bit-serial CRC unrolled over one whole word. Synthesis flattens the
  // loop into a single XOR network between the register and its next value.
  function automatic logic [11:0] crc56(input logic [11:0] c, input logic [55:0] d);
    logic [11:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 56; i++) begin
      fb = r[11] ^ d[i];
      r  = {r[10:0], 1'b0};
      if (fb) r = r ^ 12'h80F;
    end
    return r;
  endfunction

  // A start-of-frame word always reseeds, whatever the running value was.
  assign crc_base = di_sop ? CRC_INIT : crc_q;
  assign crc_step = crc56(crc_base, di);
  assign crc_fin  = crc_step ^ CRC_XOROUT;

  // Framing decisions for the current word. A sop while a frame is open
  // discards that frame and starts the new one; a non-sop word in IDLE is
  // dropped entirely, including any eop it carries.
  always_comb begin
    state_nxt = state;
    crc_nxt   = crc_q;
    rpt       = 1'b0;
    perr      = 1'b0;
    if (di_vld) begin
      if (di_sop) begin
        perr    = (state == BUSY);
        crc_nxt = crc_step;
        if (di_eop) begin
          rpt       = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = BUSY;
        end
      end else if (state == BUSY) begin
        crc_nxt = crc_step;
        if (di_eop) begin
          rpt       = 1'b1;
          state_nxt = IDLE;
        end
      end else begin
        perr = 1'b1;
      end
    end
  end

  // State, running CRC and registered result outputs. crc_o and chk_err
  // only load on a report so crc_o holds until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      crc_q     <= CRC_INIT;
      chk_vld   <= 1'b0;
      chk_err   <= 1'b0;
      crc_o     <= 12'h000;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      crc_q     <= crc_nxt;
      chk_vld   <= rpt;
      proto_err <= perr;
      if (rpt) begin
        crc_o   <= crc_fin;
        chk_err <= (crc_fin != fcs);
      end
    end
  end

`ifdef IPPCRC_CHK_CNT_EN
  // Saturating frame counters, updated from the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= 16'h0000;
      bad_cnt  <= 16'h0000;
    end else begin
      if (chk_vld && !chk_err && (good_cnt != 16'hFFFF)) good_cnt <= good_cnt + 16'd1;
      if (chk_vld && chk_err && (bad_cnt != 16'hFFFF))   bad_cnt  <= bad_cnt + 16'd1;
    end
  end
`else
  assign good_cnt = 16'h0000;
  assign bad_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_ippcrc_crc12_chk56.sv
// tb_ippcrc_crc12_chk56 -- directed self-checking bench for ippcrc_crc12_chk56.
// Inputs change 1 time unit after each rising edge; a monitor records every
// chk_vld and proto_err pulse on the falling edge together with the cycle
// number, and the directed tests compare those records with expectations.

module tb_ippcrc_crc12_chk56;

  logic        clk = 1'b0;
  logic        rst;
  logic        di_vld, di_sop, di_eop;
  logic [55:0] di;
  logic [11:0] fcs;
  logic        chk_vld, chk_err, proto_err;
  logic [11:0] crc_o;
  logic [15:0] good_cnt, bad_cnt;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_cyc;

  int          vld_cyc_q[$];
  logic [11:0] res_crc_q[$];
  logic        res_err_q[$];
  int          perr_cyc_q[$];

  localparam logic [55:0] W0 = 56'h0123456789ABCD;
  localparam logic [55:0] W1 = 56'hFEDCBA98765432;
  localparam logic [55:0] W2 = 56'h00FF00FF00FF00;
  localparam logic [55:0] W3 = 56'hA5A5A5A5A5A5A5;
  localparam logic [55:0] W4 = 56'h13579BDF2468AC;
  localparam logic [55:0] W5 = 56'hDEADBEEFCAFE01;

  ippcrc_crc12_chk56 dut (
    .clk       (clk),
    .rst       (rst),
    .di_vld    (di_vld),
    .di_sop    (di_sop),
    .di_eop    (di_eop),
    .di        (di),
    .fcs       (fcs),
    .chk_vld   (chk_vld),
    .chk_err   (chk_err),
    .crc_o     (crc_o),
    .proto_err (proto_err),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #5 clk = ~clk;

  // Cycle number, advanced on each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every result and framing-error pulse with its cycle number.
  always @(negedge clk) begin
    if (chk_vld === 1'b1) begin
      vld_cyc_q.push_back(cyc);
      res_crc_q.push_back(crc_o);
      res_err_q.push_back(chk_err);
    end
    if (proto_err === 1'b1) perr_cyc_q.push_back(cyc);
  end

  // Reference CRC by polynomial long division of the message augmented
  // with 12 zero bits; valid for a zero seed and zero output XOR.
  function automatic logic [11:0] crcModel(input logic [55:0] a, input logic [55:0] b,
                                           input logic [55:0] c, input int n);
    logic [12:0] r;
    logic [55:0] w;
    r = 13'h0;
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? a : ((k == 1) ? b : c);
      for (int i = 0; i < 56; i++) begin
        r = {r[11:0], w[i]};
        if (r[12]) r = r ^ 13'h180F;
      end
    end
    for (int i = 0; i < 12; i++) begin
      r = {r[11:0], 1'b0};
      if (r[12]) r = r ^ 13'h180F;
    end
    return r[11:0];
  endfunction

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of input; remembers the cycle it was driven in.
  task automatic applyStimulus(input logic vld, input logic sop, input logic eop,
                               input logic [55:0] d, input logic [11:0] f);
    @(posedge clk);
    #1;
    di_vld   = vld;
    di_sop   = sop;
    di_eop   = eop;
    di       = d;
    fcs      = f;
    last_cyc = cyc;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 56'h0, 12'h0);
  endtask

  // Pop the oldest recorded result and compare cycle, CRC and error flag.
  task automatic expectResult(input string tag, input int ecyc, input logic [11:0] ecrc,
                              input logic eerr);
    if (vld_cyc_q.size() == 0) begin
      checkOutput({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, "_cyc"}, vld_cyc_q.pop_front(), ecyc);
      checkOutput({tag, "_crc"}, res_crc_q.pop_front(), ecrc);
      checkOutput({tag, "_err"}, res_err_q.pop_front(), eerr);
    end
  endtask

  task automatic expectQuiet(input string tag);
    checkOutput({tag, "_novld"}, vld_cyc_q.size(), 0);
    checkOutput({tag, "_noperr"}, perr_cyc_q.size(), 0);
    vld_cyc_q.delete();
    res_crc_q.delete();
    res_err_q.delete();
    perr_cyc_q.delete();
  endtask

  task automatic expectProtoErr(input string tag, input int ecyc);
    if (perr_cyc_q.size() == 0) checkOutput({tag, "_present"}, 32'd0, 32'd1);
    else checkOutput({tag, "_cyc"}, perr_cyc_q.pop_front(), ecyc);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_chk_vld"}, chk_vld, 1'b0);
    checkOutput({tag, "_chk_err"}, chk_err, 1'b0);
    checkOutput({tag, "_crc_o"}, crc_o, 12'h000);
    checkOutput({tag, "_proto_err"}, proto_err, 1'b0);
    checkOutput({tag, "_good_cnt"}, good_cnt, 16'h0);
    checkOutput({tag, "_bad_cnt"}, bad_cnt, 16'h0);
  endtask

  task automatic checkCounters(input string tag, input logic [15:0] eg, input logic [15:0] eb);
`ifdef IPPCRC_CHK_CNT_EN
    checkOutput({tag, "_good"}, good_cnt, eg);
    checkOutput({tag, "_bad"}, bad_cnt, eb);
`else
    checkOutput({tag, "_good"}, good_cnt, 16'h0);
    checkOutput({tag, "_bad"}, bad_cnt, 16'h0);
`endif
  endtask

  // Directed test sequence.
  initial begin
    logic [11:0] m, ma, mb;
    int c0, c1;
    rst = 1'b1; di_vld = 1'b0; di_sop = 1'b0; di_eop = 1'b0; di = 56'h0; fcs = 12'h0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    idleCycles(2);

    // Single zero word: CRC of 56 zero bits from a zero seed is zero.
    applyStimulus(1'b1, 1'b1, 1'b1, 56'h0, 12'h000);
    c0 = last_cyc;
    idleCycles(3);
    expectResult("zero", c0 + 1, 12'h000, 1'b0);
    expectQuiet("zero");

    // Only the last line bit set: remainder of x^12 is 12'h80F.
    applyStimulus(1'b1, 1'b1, 1'b1, 56'h80000000000000, 12'h80F);
    c0 = last_cyc;
    idleCycles(3);
    expectResult("x12", c0 + 1, 12'h80F, 1'b0);
    expectQuiet("x12");

    // Three-word frame, gaps 0 and 2, correct fcs.
    m = crcModel(W0, W1, W2, 3);
    idleCycles(5);
    applyStimulus(1'b1, 1'b1, 1'b0, W0, 12'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, W1, 12'h0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b1, W2, m);
    c0 = last_cyc;
    idleCycles(3);
    expectResult("three_good", c0 + 1, m, 1'b0);
    expectQuiet("three_good");

    // Same frame, gaps 2 and 5, fcs bit 0 flipped.
    applyStimulus(1'b1, 1'b1, 1'b0, W0, 12'h0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b0, W1, 12'h0);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b1, W2, m ^ 12'h001);
    c0 = last_cyc;
    idleCycles(3);
    expectResult("three_bad", c0 + 1, m, 1'b1);
    expectQuiet("three_bad");
    checkOutput("crc_o_held", crc_o, m);

    // x^13 remainder is 12'h811; send it with a wrong fcs.
    applyStimulus(1'b1, 1'b1, 1'b1, 56'h40000000000000, 12'h810);
    c0 = last_cyc;
    idleCycles(3);
    expectResult("x13_bad", c0 + 1, 12'h811, 1'b1);
    expectQuiet("x13_bad");
    checkCounters("cnt_3g2b", 16'd3, 16'd2);

    // Back-to-back: A ends in cycle N, single-word B in N+1.
    ma = crcModel(W3, W4, 56'h0, 2);
    mb = crcModel(W5, 56'h0, 56'h0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, W3, 12'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, W4, ma);
    c0 = last_cyc;
    applyStimulus(1'b1, 1'b1, 1'b1, W5, mb ^ 12'h010);
    idleCycles(3);
    expectResult("b2b_a", c0 + 1, ma, 1'b0);
    expectResult("b2b_b", c0 + 2, mb, 1'b1);
    expectQuiet("b2b");

    // sop on word 2 of an open frame restarts it.
    m = crcModel(W1, W2, 56'h0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, W0, 12'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, W1, 12'h0);
    c1 = last_cyc;
    applyStimulus(1'b1, 1'b0, 1'b1, W2, m);
    c0 = last_cyc;
    idleCycles(3);
    expectProtoErr("resop_perr", c1 + 1);
    expectResult("resop", c0 + 1, m, 1'b0);
    expectQuiet("resop");

    // eop in IDLE without sop, then a plain stray word.
    applyStimulus(1'b1, 1'b0, 1'b1, W3, 12'h0);
    c0 = last_cyc;
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0, W4, 12'h0);
    c1 = last_cyc;
    idleCycles(3);
    expectProtoErr("idle_eop_perr", c0 + 1);
    expectProtoErr("idle_word_perr", c1 + 1);
    expectQuiet("idle_eop");

`ifdef IPPCRC_CHK_CNT_EN
    // Preload bad_cnt at its ceiling; a further bad frame must not wrap.
    force dut.bad_cnt = 16'hFFFF;
    idleCycles(1);
    release dut.bad_cnt;
    idleCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 56'h80000000000000, 12'h000);
    c0 = last_cyc;
    idleCycles(3);
    expectResult("sat", c0 + 1, 12'h80F, 1'b1);
    expectQuiet("sat");
    checkOutput("sat_bad_cnt", bad_cnt, 16'hFFFF);
`endif

    // Reset mid-frame, then a clean frame.
    m = crcModel(W3, W4, 56'h0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, W0, 12'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, W1, 12'h0);
    @(posedge clk);
    #1;
    di_vld = 1'b0; di_sop = 1'b0; di_eop = 1'b0;
    rst = 1'b1;
    #1;
    checkAllZero("in_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAllZero("post_reset");
    expectQuiet("rst_drop");
    applyStimulus(1'b1, 1'b1, 1'b0, W3, 12'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, W4, m);
    c0 = last_cyc;
    idleCycles(3);
    expectResult("clean", c0 + 1, m, 1'b0);
    expectQuiet("clean");
    checkCounters("cnt_after_rst", 16'd1, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
